// File: rtl/core_preempt_unit.sv
// Preempt responder for the decode cascade: accepts one jump, load/store or halt request
// from the oldest requesting slot and runs it to completion (PC redirect, memory, stdio, write-back).
module core_preempt_unit #(
   parameter int         N_SLOTS = 4,
   parameter logic [7:0] IO_ADDR = 8'hFF
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [N_SLOTS-1:0]     pre_jump_en_i,
   input  logic [N_SLOTS-1:0]     pre_jump_kind_i,
   input  logic [N_SLOTS-1:0]     pre_lsu_en_i,
   input  logic [N_SLOTS-1:0]     pre_lsu_wen_i,
   input  logic [N_SLOTS-1:0]     pre_lsu_kind_i,
   input  logic [N_SLOTS-1:0]     pre_halt_i,
   input  logic [16*N_SLOTS-1:0]  slot_instr_i,
   input  logic [16*N_SLOTS-1:0]  slot_rd_val_i,
   input  logic [16*N_SLOTS-1:0]  slot_rt_val_i,
   output logic                   busy_o,
   output logic                   pc_load_o,
   output logic [7:0]             pc_next_o,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [7:0]             mem_addr_o,
   output logic [15:0]            mem_wdata_o,
   input  logic                   mem_ready_i,
   input  logic [15:0]            mem_rdata_i,
   output logic                   stdin_ready_o,
   input  logic                   stdin_valid_i,
   input  logic [15:0]            stdin_data_i,
   output logic                   stdout_valid_o,
   output logic [15:0]            stdout_data_o,
   input  logic                   stdout_ready_i,
   output logic                   wb_en_o,
   output logic [3:0]             wb_rd_o,
   output logic [15:0]            wb_data_o,
   output logic                   halted_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_MEM, S_IO_IN, S_IO_OUT, S_WB, S_HALT
   } state_t;

   state_t state;

   logic [N_SLOTS-1:0] req;
   logic               sel_any;
   logic               sel_halt;
   logic               sel_jump;
   logic               sel_jkind;
   logic               sel_wen;
   logic               sel_lkind;
   logic [7:0]         sel_instr_lo;
   logic [3:0]         sel_rd_idx;
   logic [15:0]        sel_rd;
   logic [7:0]         sel_rt_lo;
   logic [7:0]         lsu_addr;
   logic [3:0]         rd_reg;
   logic               unused_bits;

   assign req = pre_jump_en_i | pre_lsu_en_i | pre_halt_i;

   // The upper instruction nibble and upper R[t] byte play no part here.
   assign unused_bits = ^{slot_instr_i, slot_rt_val_i};

   // Scan from the youngest slot down so the oldest requester is the one left standing.
   always_comb begin
      sel_any      = 1'b0;
      sel_halt     = 1'b0;
      sel_jump     = 1'b0;
      sel_jkind    = 1'b0;
      sel_wen      = 1'b0;
      sel_lkind    = 1'b0;
      sel_instr_lo = 8'h00;
      sel_rd_idx   = 4'h0;
      sel_rd       = 16'h0000;
      sel_rt_lo    = 8'h00;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel_any      = 1'b1;
            sel_halt     = pre_halt_i[i];
            sel_jump     = pre_jump_en_i[i];
            sel_jkind    = pre_jump_kind_i[i];
            sel_wen      = pre_lsu_wen_i[i];
            sel_lkind    = pre_lsu_kind_i[i];
            sel_instr_lo = slot_instr_i[i*16 +: 8];
            sel_rd_idx   = slot_instr_i[i*16+8 +: 4];
            sel_rd       = slot_rd_val_i[i*16 +: 16];
            sel_rt_lo    = slot_rt_val_i[i*16 +: 8];
         end
      end
   end

   assign lsu_addr = sel_lkind ? sel_instr_lo : sel_rt_lo;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state          <= S_IDLE;
         rd_reg         <= 4'h0;
         busy_o         <= 1'b0;
         pc_load_o      <= 1'b0;
         pc_next_o      <= 8'h00;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= 8'h00;
         mem_wdata_o    <= 16'h0000;
         stdin_ready_o  <= 1'b0;
         stdout_valid_o <= 1'b0;
         stdout_data_o  <= 16'h0000;
         wb_en_o        <= 1'b0;
         wb_rd_o        <= 4'h0;
         wb_data_o      <= 16'h0000;
         halted_o       <= 1'b0;
      end else begin
         pc_load_o <= 1'b0;
         pc_next_o <= 8'h00;
         case (state)
            S_IDLE: begin
               if (sel_any) begin
                  if (sel_halt) begin
                     state    <= S_HALT;
                     busy_o   <= 1'b1;
                     halted_o <= 1'b1;
                  end else if (sel_jump) begin
                     pc_load_o <= 1'b1;
                     pc_next_o <= sel_jkind ? sel_instr_lo : sel_rd[7:0];
                  end else begin
                     busy_o <= 1'b1;
                     rd_reg <= sel_rd_idx;
                     if (lsu_addr == IO_ADDR && !sel_wen) begin
                        state         <= S_IO_IN;
                        stdin_ready_o <= 1'b1;
                     end else if (lsu_addr == IO_ADDR) begin
                        state          <= S_IO_OUT;
                        stdout_valid_o <= 1'b1;
                        stdout_data_o  <= sel_rd;
                     end else begin
                        state       <= S_MEM;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= sel_wen;
                        mem_addr_o  <= lsu_addr;
                        mem_wdata_o <= sel_rd;
                     end
                  end
               end
            end
            S_MEM: begin
               if (mem_ready_i) begin
                  mem_req_o   <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= 8'h00;
                  mem_wdata_o <= 16'h0000;
                  if (mem_we_o) begin
                     state  <= S_IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     state     <= S_WB;
                     wb_en_o   <= (rd_reg != 4'h0);
                     wb_rd_o   <= rd_reg;
                     wb_data_o <= mem_rdata_i;
                  end
               end
            end
            S_IO_IN: begin
               if (stdin_valid_i) begin
                  state         <= S_WB;
                  stdin_ready_o <= 1'b0;
                  wb_en_o       <= (rd_reg != 4'h0);
                  wb_rd_o       <= rd_reg;
                  wb_data_o     <= stdin_data_i;
               end
            end
            S_IO_OUT: begin
               if (stdout_ready_i) begin
                  state          <= S_IDLE;
                  busy_o         <= 1'b0;
                  stdout_valid_o <= 1'b0;
                  stdout_data_o  <= 16'h0000;
               end
            end
            S_WB: begin
               state     <= S_IDLE;
               busy_o    <= 1'b0;
               wb_en_o   <= 1'b0;
               wb_rd_o   <= 4'h0;
               wb_data_o <= 16'h0000;
            end
            S_HALT: ;
            default: begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   // Younger slots queued behind a halting slot are dead, so only non-halt selections must be unique.
   a_single_requester: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state == S_IDLE && !sel_halt) |-> $onehot0(req));

endmodule
